// File: rtl/ef_apb_initiator.sv
// ef_apb_initiator
// ----------------
// APB3 bus master. Each command accepted on the cmd_* valid/ready stream
// becomes a single APB transfer (SETUP then ACCESS). Its result is returned on
// the rsp_* valid/ready stream. A wait counter bounds the ACCESS phase so that
// a slave which never raises PREADY cannot stall the initiator.
//
// Ports
//   PCLK, PRESETn          clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake; cmd_ready is high only in IDLE
//   cmd_write/addr/wdata   command payload, latched on acceptance
//   rsp_valid/rsp_ready    response handshake
//   rsp_rdata              read data (0 for writes and timeouts)
//   rsp_err                PSLVERR at completion, or timeout
//   rsp_timeout            transfer aborted by the wait counter
//   busy                   initiator is not idle
//   PSEL..PSLVERR          APB3 master interface
module ef_apb_initiator #(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          rsp_timeout,
    output logic          busy,
    output logic          PSEL,
    output logic          PENABLE,
    output logic          PWRITE,
    output logic [AW-1:0] PADDR,
    output logic [DW-1:0] PWDATA,
    input  logic [DW-1:0] PRDATA,
    input  logic          PREADY,
    input  logic          PSLVERR
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    logic [1:0]    r_rstSync;
    logic          w_rstN;
    state_t        r_state;
    logic [CW-1:0] r_count;
    logic          r_psel;
    logic          r_penable;
    logic          r_pwrite;
    logic [AW-1:0] r_paddr;
    logic [DW-1:0] r_pwdata;
    logic          r_rspValid;
    logic [DW-1:0] r_rspRdata;
    logic          r_rspErr;
    logic          r_rspTimeout;
    logic          r_busy;

    // Reset synchroniser: assertion reaches the FSM immediately through the
    // asynchronous clear, release is aligned to PCLK two edges later.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_rstSync <= 2'b00;
        end else begin
            r_rstSync <= {r_rstSync[0], 1'b1};
        end
    end

    assign w_rstN = r_rstSync[1];

    // Transfer FSM. Every interface output is a register updated here.
    always_ff @(posedge PCLK or negedge w_rstN) begin
        if (!w_rstN) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_paddr      <= '0;
            r_pwdata     <= '0;
            r_rspValid   <= 1'b0;
            r_rspRdata   <= '0;
            r_rspErr     <= 1'b0;
            r_rspTimeout <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_pwrite  <= cmd_write;
                        r_paddr   <= cmd_addr;
                        r_pwdata  <= cmd_wdata;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_count   <= '0;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        r_rspRdata   <= r_pwrite ? '0 : PRDATA;
                        r_rspErr     <= PSLVERR;
                        r_rspTimeout <= 1'b0;
                        r_psel       <= 1'b0;
                        r_penable    <= 1'b0;
                        r_rspValid   <= 1'b1;
                        r_state      <= RESP;
                    end else if ((TIMEOUT != 0) && (r_count == CNT_LAST)) begin
                        // Abort: the slave has held PREADY low for TIMEOUT cycles.
                        r_rspRdata   <= '0;
                        r_rspErr     <= 1'b1;
                        r_rspTimeout <= 1'b1;
                        r_psel       <= 1'b0;
                        r_penable    <= 1'b0;
                        r_rspValid   <= 1'b1;
                        r_state      <= RESP;
                    end else if (r_count != CNT_MAX) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = (r_state == IDLE);
    assign PSEL        = r_psel;
    assign PENABLE     = r_penable;
    assign PWRITE      = r_pwrite;
    assign PADDR       = r_paddr;
    assign PWDATA      = r_pwdata;
    assign rsp_valid   = r_rspValid;
    assign rsp_rdata   = r_rspRdata;
    assign rsp_err     = r_rspErr;
    assign rsp_timeout = r_rspTimeout;
    assign busy        = r_busy;

endmodule

// File: tb/tb_ef_apb_initiator.sv
// tb_ef_apb_initiator
// -------------------
// Directed bench for ef_apb_initiator built with an 8-cycle bus timeout.
// The bench plays the APB slave itself, cycle by cycle, and keeps expected
// responses in a queue that is filled when a command is issued and drained
// when the response handshake completes.
module tb_ef_apb_initiator;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TIMEOUT = 8;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          tmo;
    } rsp_t;

    logic          PCLK;
    logic          PRESETn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          busy;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    int   checks = 0;
    int   errors = 0;
    rsp_t expQ[$];

    ef_apb_initiator #(
        .AW(AW),
        .DW(DW),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK(PCLK),
        .PRESETn(PRESETn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .busy(busy),
        .PSEL(PSEL),
        .PENABLE(PENABLE),
        .PWRITE(PWRITE),
        .PADDR(PADDR),
        .PWDATA(PWDATA),
        .PRDATA(PRDATA),
        .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    // Free-running 100 MHz clock.
    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // Single comparison point: counts the check and reports any difference.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one command and act as the slave until the initiator leaves
    // ACCESS. waits = number of PREADY-low cycles before the ready cycle;
    // stuck = never raise PREADY. Non-ready cycles drive garbage PRDATA and
    // PSLVERR=1 so that sampling outside the ready cycle is caught.
    task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input int waits,
                                 input logic [DW-1:0] prdata, input logic slverr,
                                 input logic stuck);
        rsp_t e;
        int   n;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        check("cmd_ready_idle", cmd_ready, 1'b1);
        if (stuck) begin
            e.rdata = '0;
            e.err   = 1'b1;
            e.tmo   = 1'b1;
        end else begin
            e.rdata = wr ? '0 : prdata;
            e.err   = slverr;
            e.tmo   = 1'b0;
        end
        expQ.push_back(e);

        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        check("setup_psel", PSEL, 1'b1);
        check("setup_penable", PENABLE, 1'b0);
        check("setup_pwrite", PWRITE, wr);
        check("setup_paddr", PADDR, addr);
        if (wr) check("setup_pwdata", PWDATA, wdata);
        check("setup_busy", busy, 1'b1);
        check("setup_cmd_ready", cmd_ready, 1'b0);

        @(posedge PCLK); #1;
        check("access_psel", PSEL, 1'b1);
        n = 0;
        while (PSEL === 1'b1 && n < 20) begin
            check("access_penable", PENABLE, 1'b1);
            check("access_paddr", PADDR, addr);
            check("access_rsp_valid", rsp_valid, 1'b0);
            PREADY  = !stuck && (n == waits);
            PRDATA  = (n == waits) ? prdata : (32'hDEAD_0000 | 32'(n));
            PSLVERR = (n == waits) ? slverr : 1'b1;
            @(posedge PCLK); #1;
            n++;
        end
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = 32'hBAD0_BAD0;
        check("access_cycles", n, stuck ? TIMEOUT : waits + 1);
        check("end_penable", PENABLE, 1'b0);
        check("end_rsp_valid", rsp_valid, 1'b1);
    endtask

    // Hold off the response for 'hold' cycles (optionally presenting the next
    // command meanwhile), then complete the handshake and compare against the
    // oldest expected response.
    task automatic checkOutput(input int hold, input logic nextValid,
                               input logic [AW-1:0] nextAddr, input logic [DW-1:0] nextWdata);
        rsp_t e;
        checks++;
        assert (expQ.size() > 0) else begin
            errors++;
            $error("[TB] FAIL rsp_queue observed empty expected entry");
        end
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
        end else begin
            e.rdata = 'x;
            e.err   = 1'bx;
            e.tmo   = 1'bx;
        end
        rsp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            if (nextValid) begin
                cmd_valid = 1'b1;
                cmd_write = 1'b1;
                cmd_addr  = nextAddr;
                cmd_wdata = nextWdata;
            end
            check("hold_rsp_valid", rsp_valid, 1'b1);
            check("hold_cmd_ready", cmd_ready, 1'b0);
            check("hold_psel", PSEL, 1'b0);
            check("hold_rdata", rsp_rdata, e.rdata);
            check("hold_err", rsp_err, e.err);
            check("hold_timeout", rsp_timeout, e.tmo);
            @(posedge PCLK); #1;
        end
        rsp_ready = 1'b1;
        check("rsp_valid", rsp_valid, 1'b1);
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", rsp_err, e.err);
        check("rsp_timeout", rsp_timeout, e.tmo);
        @(posedge PCLK); #1;
        rsp_ready = 1'b0;
        check("post_rsp_valid", rsp_valid, 1'b0);
        check("post_cmd_ready", cmd_ready, 1'b1);
        check("post_busy", busy, 1'b0);
        check("post_psel", PSEL, 1'b0);
    endtask

    initial begin
        $display("[TB] start");
        PRESETn   = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        // Power-on reset and reset-state checks.
        #2 PRESETn = 1'b0;
        #10;
        check("rst_psel", PSEL, 1'b0);
        check("rst_penable", PENABLE, 1'b0);
        check("rst_pwrite", PWRITE, 1'b0);
        check("rst_paddr", PADDR, 16'h0000);
        check("rst_pwdata", PWDATA, 32'h0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_rsp_timeout", rsp_timeout, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        repeat (2) @(posedge PCLK);
        #2 PRESETn = 1'b1;
        repeat (3) @(posedge PCLK);
        #1;

        $display("[TB] write, zero wait");
        applyStimulus(1'b1, 16'h0008, 32'h0000_000A, 0, 32'h1234_5678, 1'b0, 1'b0);
        checkOutput(0, 1'b0, '0, '0);

        $display("[TB] read, three wait states");
        applyStimulus(1'b0, 16'h0F08, 32'hFFFF_FFFF, 3, 32'h0000_0008, 1'b0, 1'b0);
        checkOutput(0, 1'b0, '0, '0);

        $display("[TB] read with slave error");
        applyStimulus(1'b0, 16'h0000, 32'h0, 1, 32'h5A5A_0001, 1'b1, 1'b0);
        checkOutput(1, 1'b0, '0, '0);

        $display("[TB] read timeout");
        applyStimulus(1'b0, 16'h0010, 32'h0, 0, 32'h7777_7777, 1'b0, 1'b1);
        checkOutput(0, 1'b0, '0, '0);

        $display("[TB] queued writes with response backpressure");
        applyStimulus(1'b1, 16'h0004, 32'h0000_00C3, 0, 32'h0, 1'b0, 1'b0);
        checkOutput(5, 1'b1, 16'h0004, 32'h0000_0091);
        applyStimulus(1'b1, 16'h0004, 32'h0000_0091, 2, 32'h0, 1'b0, 1'b0);
        checkOutput(0, 1'b0, '0, '0);

        $display("[TB] reset during ACCESS");
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 16'h0020;
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        @(posedge PCLK); #1;
        @(posedge PCLK); #1;
        check("pre_rst_psel", PSEL, 1'b1);
        #2 PRESETn = 1'b0;
        #1;
        check("async_rst_psel", PSEL, 1'b0);
        check("async_rst_penable", PENABLE, 1'b0);
        check("async_rst_rsp_valid", rsp_valid, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        @(posedge PCLK);
        #2 PRESETn = 1'b1;
        repeat (3) @(posedge PCLK);
        #1;
        check("post_rst_cmd_ready", cmd_ready, 1'b1);
        check("post_rst_rsp_valid", rsp_valid, 1'b0);
        check("post_rst_psel", PSEL, 1'b0);
        applyStimulus(1'b0, 16'h0F0C, 32'h0, 2, 32'h1357_9BDF, 1'b0, 1'b0);
        checkOutput(0, 1'b0, '0, '0);

        check("queue_empty", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ef_apb_initiator.md
Name: ef_apb_initiator

Overview:
- APB initiator (bus master) that turns a simple valid/ready command stream into single APB3 transfers and returns each result on a valid/ready response stream.
- Lets firmware-less logic, such as a debug/UART command bridge, drive EF APB peripherals (EF_UART_APB and siblings) exactly as a CPU bridge would.
- Adds a bus timeout so a hung slave cannot stall the initiator.

Parameters:
- AW, 16, APB address width.
- DW, 32, APB data width.
- TIMEOUT, 255, max ACCESS-phase cycles waiting for PREADY; 0 disables the timeout.

Ports:
- PCLK  input  1  clock; all logic rising-edge.
- PRESETn  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  initiator accepts a command this cycle.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  AW  transfer address.
- cmd_wdata  input  DW  write data; ignored for reads.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  DW  read data; 0 for writes.
- rsp_err  output  1  PSLVERR sampled at completion, or timeout.
- rsp_timeout  output  1  transfer aborted by timeout.
- busy  output  1  state != IDLE.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PADDR  output  AW  APB address.
- PWDATA  output  DW  APB write data.
- PRDATA  input  DW  APB read data.
- PREADY  input  1  APB ready.
- PSLVERR  input  1  APB slave error.

Behaviour:
- Reset (async assert, sync deassert inside the block): state=IDLE; PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout, busy = 0; PADDR, PWDATA, rsp_rdata = 0; wait counter = 0.
- cmd_ready = (state == IDLE). Purely combinational from state; no dependence on cmd_valid.
- FSM, all outputs registered:
  - IDLE: on cmd_valid && cmd_ready, latch cmd_write/cmd_addr/cmd_wdata into PWRITE/PADDR/PWDATA and set PSEL=1, PENABLE=0 -> SETUP.
  - SETUP: exactly one cycle. PENABLE<=1, counter<=0 -> ACCESS.
  - ACCESS: PSEL=PENABLE=1 and PADDR/PWDATA/PWRITE held stable.
    - PREADY=1: capture rsp_rdata = PWRITE ? 0 : PRDATA, rsp_err = PSLVERR, rsp_timeout = 0; drop PSEL/PENABLE; rsp_valid<=1 -> RESP.
    - Else if TIMEOUT != 0 and counter == TIMEOUT-1: drop PSEL/PENABLE; rsp_err=1, rsp_timeout=1, rsp_rdata=0, rsp_valid<=1 -> RESP.
    - Else counter++ (counter width = clog2(TIMEOUT+1), min 1; saturates, never wraps).
  - RESP: hold rsp_* stable while rsp_valid && !rsp_ready. On rsp_ready: rsp_valid<=0 -> IDLE.
- Minimum latency: cmd accept at edge N -> SETUP at N+1 -> ACCESS at N+2. With PREADY high in ACCESS, rsp_valid is high from N+3.
- Back-to-back transfers:
  - After rsp handshake at edge M, state is IDLE in cycle M+1, so the next command can be accepted.
  - PSEL is low for at least one cycle between transfers.
  - Throughput is 1 transfer per 4 cycles minimum.
- PSLVERR is only sampled in the cycle PREADY=1 in ACCESS; it is ignored otherwise.
- PRDATA is ignored for writes.
- PADDR/PWDATA/PWRITE keep their last value after a transfer (no forced zero); PSEL=0 marks them don't-care.
- Reset mid-transfer: all APB outputs drop to 0 immediately and asynchronously. Any pending response is lost; no response is generated.
- TIMEOUT=1: timeout fires in the first ACCESS cycle if PREADY=0.
- An aborted transfer never re-asserts PSEL for the same command; there is no retry.

Test Plan:
- Write 0x0000_000A to 0x0008 with zero-wait slave -> PSEL rises 1 cycle after accept, PENABLE one cycle later, PWRITE=1, PADDR=0x0008, PWDATA=0xA; rsp_valid 3 cycles after accept with rsp_err=0, rsp_rdata=0.
- Read 0x0F08 with slave inserting 3 wait states, returning PRDATA=0x0000_0008 -> ACCESS lasts 4 cycles, PADDR stable throughout; rsp_rdata=0x8, rsp_err=0.
- Read 0x0000 with PSLVERR=1 on the PREADY cycle -> rsp_err=1, rsp_timeout=0, rsp_rdata=PRDATA value.
- TIMEOUT=8, PREADY stuck low -> exactly 8 ACCESS cycles, then PSEL=PENABLE=0; rsp_err=1, rsp_timeout=1; rsp_rdata=0.
- Two queued commands (write 0xC3 to 0x0004, write 0x91 to 0x0004) with rsp_ready held low 5 cycles on the first -> cmd_ready stays 0 and rsp_* stay stable until the handshake; the second transfer starts only afterwards; two distinct APB transfers are seen with PSEL low in between.
- Assert PRESETn=0 during ACCESS -> PSEL, PENABLE, rsp_valid go 0 without waiting for a clock edge; after release, cmd_ready=1 and a fresh read completes normally.
